// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed common-anode seven-segment scanner with load shadows, hex glyphs, leading-zero blanking and guard interval
module seven_seg_scan #(
    parameter int DIGITS      = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 0,
    parameter bit HEX_EN      = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   dp_q, dp_d, an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dpo_q, dpo_d;
    logic                guard, wrap, supp, zero_run;
    logic [3:0]          code;
    if (GUARD == 0) begin : g_no_guard
        assign guard = 1'b0;
    end else begin : g_guard
        assign guard = pre_q < PW'(GUARD);
    end
    always_comb begin
        wrap  = pre_q == PW'(REFRESH_DIV - 1);
        pre_d = wrap ? '0 : pre_q + 1'b1;
        idx_d = !wrap ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        val_d = load ? value : val_q;
        dp_d  = load ? dp_in : dp_q;
        code  = val_q[idx_q*4 +: 4];
        // zero_run stays set while every digit from the top down to i is a bare zero
        zero_run = 1'b1;
        supp     = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (val_q[4*i +: 4] == 4'd0) && !dp_q[i];
            if (IW'(i) == idx_q) supp = zero_run;
        end
        supp  = supp && blank_lz;
        seg_d = (guard || supp || (code > 4'd9 && !HEX_EN)) ? 7'h7F : GLYPH[code];
        dpo_d = guard || supp || !dp_q[idx_q];
        an_d  = guard ? '1 : ~(DIGITS'(1) << idx_q);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
            val_q <= '0;
            dp_q  <= '0;
            seg_q <= 7'h7F;
            dpo_q <= 1'b1;
            an_q  <= '1;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            val_q <= val_d;
            dp_q  <= dp_d;
            seg_q <= seg_d;
            dpo_q <= dpo_d;
            an_q  <= an_d;
        end
    end
    assign seg = seg_q;
    assign dp  = dpo_q;
    assign an  = an_q;
endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It captures a packed BCD/hex value with per-digit decimal points on a load strobe and scans the digits one at a time at a programmable refresh rate. It adds optional hex glyphs, leading-zero suppression and an anti-ghosting blank interval. It sits between datapath/display-formatting logic and the board's shared segment bus and digit-enable pins, and replaces per-digit static combinational decoders.

## Interface
- DIGITS, 6: number of digits scanned, 1..16.
- REFRESH_DIV, 50000: clock cycles each digit is enabled per scan slot, ≥ 2.
- GUARD, 0: cycles at the start of each slot with all digits off (anti-ghost), < REFRESH_DIV.
- HEX_EN, 1: 1 = codes 10..15 show A b C d E F; 0 = codes 10..15 blank.

- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- load  in  1  capture strobe for value/dp_in.
- value  in  4*DIGITS  packed digit codes; digit 0 = value[3:0] = rightmost.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros (level, sampled every cycle).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit enables, active-low, at most one low.

## Operation
- Shadow registers: on a clock edge with load=1, capture value into val_q and dp_in into dp_q. Display uses only shadows. A load mid-slot changes the glyph of the current digit on the following cycle; the scan position is unaffected.
- Prescaler pre_q counts 0..REFRESH_DIV-1 and wraps. When pre_q = REFRESH_DIV-1, idx_q advances. idx_q wraps DIGITS-1 -> 0. Full scan period = DIGITS*REFRESH_DIV cycles.
- Slot phases:
  - BLANK: pre_q < GUARD. an all 1, seg 7'h7F, dp 1.
  - DRIVE: pre_q ≥ GUARD. an bit idx_q = 0, all others 1.
- Glyph encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - With HEX_EN=0, codes 10..15 give 1111111.
- Leading-zero suppression (blank_lz=1):
  - Scan from digit DIGITS-1 downward. A digit is suppressed while it and every higher digit have code 0 and dp_q=0.
  - Digit 0 is never suppressed.
  - A suppressed digit still has its an bit driven low, with seg=1111111 and dp=1.
- dp output = ~dp_q[idx_q] during DRIVE.

## Timing
- Reset (reset_n=0 at an edge): pre_q=0, idx_q=0, val_q=0, dp_q=0; seg=7'h7F, dp=1, an=all 1.
- seg, dp and an are registered. Each is a function of (pre_q, idx_q, val_q, dp_q, blank_lz) as they stood before the edge, giving 1-cycle latency.
- First edge after reset release:
  - GUARD=0: an=~1 (digit 0 low), seg=1000000.
  - GUARD>0: outputs stay off for GUARD edges.
- Load latency: load high at edge k updates the shadows at k. The new glyph appears on the outputs at edge k+1 if that digit is in DRIVE.
- Reset asserted mid-scan: all state clears at that edge. Outputs are off from the next edge and no partial glyph is held.
- Simultaneous load and slot advance: both take effect. The new digit is shown with the new data.
- DIGITS=1: idx_q stays 0 and an[0] toggles only for GUARD blanking.

## Test plan
- Reset/idle: DIGITS=4, REFRESH_DIV=4, GUARD=0, hold reset_n=0 for 3 cycles then release. Required response:
  - While in reset: seg=7'h7F, an=4'hF.
  - Afterwards: an cycles E,D,B,7, each for 4 cycles; seg=1000000 throughout.
- Decimal data: load value=16'h1234 with dp_in=4'b0100. Required response:
  - Slots show 4=0011001, 3=0110000, 2=0100100 (with dp=0), 1=1111001.
- Hex mode: load 16'hAbCF.
  - HEX_EN=1: seg sequence is 0001110, 1000110, 0000011, 0001000.
  - HEX_EN=0: every slot has seg=1111111 while an still scans.
- Leading zeros: value=16'h0050, blank_lz=1. Required response:
  - Digits 3 and 2 are blank; digit 1 shows 0010010; digit 0 shows 1000000.
  - Setting dp_in[3]=1 makes digit 3 show 0 with dp lit.
- Guard interval: REFRESH_DIV=8, GUARD=2. Each slot shows exactly 2 cycles with an=all 1 followed by 6 driven cycles. Across a whole run, more than one an bit is never low at the same time.
- Mid-operation events: reset_n pulsed low for 1 cycle mid-slot gives outputs off on the next edge and a scan restart at digit 0. A load on the same edge as a slot advance shows the new data in the new slot on the next edge.
